nerv_axi_rd_arbiter: RTL and testbench
======================================

Name: nerv_axi_rd_arbiter

Overview:
- N-to-1 round-robin arbiter sharing one AXI4 read port between N requesters, for example the instruction-fetch side and the data side of the NERV cache subsystem.
- Sequences exactly one burst at a time: AR handshake, then all R beats up to RLAST, before the next grant.
- The master side is compliant with the AXI4 protocol checker configured with MAX_RD_BURSTS=1 and SOURCE agent type.

Parameters:
NREQ, 2, number of requesters (2..4)
ADDR_W, 32, address width
DATA_W, 32, data width
ID_W, 2, width of m_arid; must be at least clog2(NREQ)

Ports:
clock  in  1  clock
resetn  in  1  asynchronous active-low reset
s_arvalid  in  NREQ  per-requester AR valid
s_arready  out  NREQ  per-requester AR ready
s_araddr  in  NREQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
s_arlen  in  NREQ*8  packed burst lengths
s_rvalid  out  NREQ  per-requester R valid
s_rready  in  NREQ  per-requester R ready
s_rdata  out  DATA_W  R data, broadcast to all requesters
s_rresp  out  2  R response, broadcast
s_rlast  out  1  R last, broadcast
m_arvalid/m_arready  out/in  1/1  master AR handshake
m_araddr  out  ADDR_W  master address
m_arlen  out  8  master burst length
m_arid  out  ID_W  index of the granted requester
m_rvalid/m_rready  in/out  1/1  master R handshake
m_rdata/m_rresp/m_rlast/m_rid  in  DATA_W/2/1/ID_W  master R payload

Behaviour:
- Fixed master fields, driven constant: ARSIZE=log2(DATA_W/8), ARBURST=INCR, ARCACHE/ARPROT/ARLOCK/ARQOS=0.
- Reset (resetn low, asynchronous):
  - state=IDLE, grant=0, last_grant=NREQ-1, so requester 0 wins first.
  - All outputs 0: m_arvalid, m_rready, s_arready, s_rvalid.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any s_arvalid is high, register grant = first requester at or after (last_grant+1) mod NREQ with s_arvalid high, then go to ADDR.
  - Otherwise stay in IDLE.
  - No outputs are asserted in IDLE; the grant takes 1 cycle.
- ADDR:
  - m_arvalid=1.
  - m_araddr, m_arlen = requester[grant] fields (combinational mux); m_arid=grant.
  - s_arready[grant]=m_arready; all other s_arready bits are 0.
  - On m_arvalid & m_arready, go to DATA.
  - A requester must hold arvalid and its fields stable until its arready. If it drops arvalid, behaviour is undefined.
- DATA:
  - s_rvalid[grant]=m_rvalid; other s_rvalid bits are 0.
  - m_rready=s_rready[grant].
  - s_rdata/s_rresp/s_rlast pass through combinationally with zero added latency.
  - On m_rvalid & m_rready & m_rlast: last_grant<=grant, then go to IDLE.
- Master R handling: m_rready=0 outside DATA, so beats are never accepted without an outstanding burst. m_rid is not used for routing.
- Occupancy: at most one burst is outstanding. The earliest new AR after an RLAST beat is 2 cycles later (IDLE then ADDR).
- Fairness: round robin guarantees that a continuously requesting requester waits at most NREQ-1 bursts.
- Simultaneous events: new s_arvalid assertions during ADDR/DATA are held off (s_arready=0) until the next IDLE arbitration. A single-beat burst (arlen=0) completes DATA on its only beat.
- Reset mid-burst: the FSM returns to IDLE immediately; no partial completion is signalled. Master-side recovery relies on the system reset being shared with the interconnect.

Optional Feature:
- Macro: NERV_AXI_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index requester with s_arvalid wins; last_grant is ignored.
- Undefined (default): round robin as described above.
- FSM, latency and all handshake rules are identical in both modes.

Test Plan:
- Single request: req0 araddr=0x100, arlen=1, m_arready held 1. Expect: m_arvalid in cycle 2, m_arid=0, two beats routed only to s_rvalid[0], return to IDLE after RLAST.
- Contention: req0 and req1 both valid from reset. Expect grant order 0,1,0,1 over 4 bursts with round robin. With NERV_AXI_ARB_FIXED_PRIO_EN, expect 0,0,0,0 while req0 stays valid.
- AR backpressure: m_arready low for 4 cycles. Expect m_arvalid held 1 with m_araddr/m_arlen stable, s_arready[grant] rises in the same cycle as m_arready.
- R backpressure: s_rready[1]=0 for 3 cycles mid-burst. Expect m_rready=0 over the same cycles, no beat lost, data order preserved.
- Isolation: m_rvalid=1 driven while in IDLE. Expect m_rready=0 and all s_rvalid=0.
- Async reset during DATA, second beat pending. Expect all outputs 0 before the next clock edge, and the next grant goes to req0.

Source files
------------

// File: rtl/nerv_axi_rd_arbiter_if.sv
// Bundle of the per-requester AR/R lanes and the single shared AXI4 read master port.
// The arbiter connects through modport master; the requesters and memory connect through modport slave.
interface nerv_axi_rd_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 2
);
  logic [NREQ-1:0]        s_arvalid;
  logic [NREQ-1:0]        s_arready;
  logic [NREQ*ADDR_W-1:0] s_araddr;
  logic [NREQ*8-1:0]      s_arlen;
  logic [NREQ-1:0]        s_rvalid;
  logic [NREQ-1:0]        s_rready;
  logic [DATA_W-1:0]      s_rdata;
  logic [1:0]             s_rresp;
  logic                   s_rlast;

  logic                   m_arvalid;
  logic                   m_arready;
  logic [ADDR_W-1:0]      m_araddr;
  logic [7:0]             m_arlen;
  logic [ID_W-1:0]        m_arid;
  logic [2:0]             m_arsize;
  logic [1:0]             m_arburst;
  logic [3:0]             m_arcache;
  logic [2:0]             m_arprot;
  logic                   m_arlock;
  logic [3:0]             m_arqos;
  logic                   m_rvalid;
  logic                   m_rready;
  logic [DATA_W-1:0]      m_rdata;
  logic [1:0]             m_rresp;
  logic                   m_rlast;
  logic [ID_W-1:0]        m_rid;

  modport master (
    input  s_arvalid, s_araddr, s_arlen, s_rready,
           m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
    output s_arready, s_rvalid, s_rdata, s_rresp, s_rlast,
           m_arvalid, m_araddr, m_arlen, m_arid, m_arsize, m_arburst,
           m_arcache, m_arprot, m_arlock, m_arqos, m_rready
  );

  modport slave (
    output s_arvalid, s_araddr, s_arlen, s_rready,
           m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
    input  s_arready, s_rvalid, s_rdata, s_rresp, s_rlast,
           m_arvalid, m_araddr, m_arlen, m_arid, m_arsize, m_arburst,
           m_arcache, m_arprot, m_arlock, m_arqos, m_rready
  );
endinterface

// File: rtl/nerv_axi_rd_arbiter.sv
// N-to-1 AXI4 read arbiter: one burst at a time (AR, then R beats up to RLAST), round-robin grant.
// Define NERV_AXI_ARB_FIXED_PRIO_EN to select fixed priority (lowest index wins) instead.
module nerv_axi_rd_arbiter #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 2
) (
  input  logic                  clock,
  input  logic                  resetn,
  nerv_axi_rd_arbiter_if.master bus
);
  localparam int              GW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [GW-1:0]   LAST_IDX = GW'(NREQ - 1);
  localparam logic [2:0]      ARSIZE   = 3'($clog2(DATA_W / 8));

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [GW-1:0]     r_grant;
  logic [GW-1:0]     r_last_grant;
  logic [GW-1:0]     w_pick;
  logic [GW-1:0]     w_idx;
  logic              w_any_req;
  logic              w_rready;
  logic              w_r_done;
  logic [NREQ-1:0]   w_sel;
  logic [ADDR_W-1:0] w_araddr [NREQ];
  logic [7:0]        w_arlen  [NREQ];
  logic              w_unused_sink;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign w_araddr[gi] = bus.s_araddr[gi*ADDR_W +: ADDR_W];
    assign w_arlen[gi]  = bus.s_arlen[gi*8 +: 8];
    assign w_sel[gi]    = (r_grant == GW'(gi));
  end

  assign w_any_req = |bus.s_arvalid;
  assign w_rready  = (r_state == S_DATA) && bus.s_rready[r_grant];
  assign w_r_done  = w_rready && bus.m_rvalid && bus.m_rlast;

  // Scan descending and overwrite, so the nearest candidate in priority order wins.
  always_comb begin
    w_pick = '0;
    w_idx  = '0;
`ifdef NERV_AXI_ARB_FIXED_PRIO_EN
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = GW'(k);
      if (bus.s_arvalid[w_idx]) w_pick = w_idx;
    end
`else
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = GW'((int'(r_last_grant) + k) % NREQ);
      if (bus.s_arvalid[w_idx]) w_pick = w_idx;
    end
`endif
  end

`ifdef NERV_AXI_ARB_FIXED_PRIO_EN
  assign w_unused_sink = ^{bus.m_rid, r_last_grant};
`else
  assign w_unused_sink = ^bus.m_rid;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= LAST_IDX;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && w_any_req) r_grant <= w_pick;
      if (w_r_done) r_last_grant <= r_grant;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req)      w_state_next = S_ADDR;
      S_ADDR:  if (bus.m_arready)  w_state_next = S_DATA;
      S_DATA:  if (w_r_done)       w_state_next = S_IDLE;
      default:                     w_state_next = S_IDLE;
    endcase
  end

  // Address fields are zeroed outside ADDR so nothing leaks onto the master port while idle.
  always_comb begin
    bus.m_arvalid = 1'b0;
    bus.m_araddr  = '0;
    bus.m_arlen   = '0;
    bus.m_arid    = '0;
    bus.s_arready = '0;
    bus.s_rvalid  = '0;
    bus.m_rready  = w_rready;
    bus.s_rdata   = bus.m_rdata;
    bus.s_rresp   = bus.m_rresp;
    bus.s_rlast   = bus.m_rlast;
    if (r_state == S_ADDR) begin
      bus.m_arvalid = 1'b1;
      bus.m_araddr  = w_araddr[r_grant];
      bus.m_arlen   = w_arlen[r_grant];
      bus.m_arid    = ID_W'(r_grant);
      bus.s_arready = bus.m_arready ? w_sel : '0;
    end
    if (r_state == S_DATA) begin
      bus.s_rvalid = bus.m_rvalid ? w_sel : '0;
    end
  end

  assign bus.m_arsize  = ARSIZE;
  assign bus.m_arburst = 2'b01;
  assign bus.m_arcache = 4'd0;
  assign bus.m_arprot  = 3'd0;
  assign bus.m_arlock  = 1'b0;
  assign bus.m_arqos   = 4'd0;

endmodule

// File: tb/tb_nerv_axi_rd_arbiter.sv
// Directed bench for nerv_axi_rd_arbiter with two requesters; expectations follow the
// NERV_AXI_ARB_FIXED_PRIO_EN setting of the build.
module tb_nerv_axi_rd_arbiter;
  localparam int NREQ   = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 2;

  logic clock;
  logic resetn;
  int   n_assert = 0;
  int   n_fail   = 0;

  nerv_axi_rd_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  nerv_axi_rd_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int id, input logic [31:0] addr, input logic [7:0] len);
    bus.s_araddr[id*ADDR_W +: ADDR_W] = addr;
    bus.s_arlen[id*8 +: 8]            = len;
  endtask

  // Presents one R beat, checks routing, then clocks it through.
  task automatic beat(input logic [31:0] d, input logic last, input logic [1:0] exp_sel);
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = d;
    bus.m_rresp  = d[1:0];
    bus.m_rlast  = last;
    #1;
    check("s_rvalid", bus.s_rvalid, exp_sel);
    check("s_rdata",  bus.s_rdata,  d);
    check("s_rresp",  bus.s_rresp,  d[1:0]);
    check("s_rlast",  bus.s_rlast,  last);
    check("m_rready", bus.m_rready, (exp_sel & bus.s_rready) != 2'b00);
    tick();
    bus.m_rvalid = 1'b0;
  endtask

  // Waits for AR from the expected requester (m_arready assumed high), then runs its beats.
  task automatic run_burst(input int id, input logic [31:0] addr, input int nbeats, input bit clr);
    int          waited;
    logic [1:0]  sel;
    waited = 0;
    sel    = 2'(1 << id);
    while (bus.m_arvalid !== 1'b1 && waited < 8) begin
      tick();
      waited++;
    end
    check("ar_wait", bus.m_arvalid, 1'b1);
    check("m_arid",    bus.m_arid,    2'(id));
    check("m_araddr",  bus.m_araddr,  addr);
    check("m_arlen",   bus.m_arlen,   8'(nbeats - 1));
    check("s_arready", bus.s_arready, sel);
    tick();
    if (clr) bus.s_arvalid[id] = 1'b0;
    for (int b = 0; b < nbeats; b++) beat(addr + 32'(b), b == nbeats - 1, sel);
    $display("burst id=%0d addr=%08h beats=%0d", id, addr, nbeats);
  endtask

  initial begin
    int exp_order [4];
    resetn        = 1'b0;
    bus.s_arvalid = '0;
    bus.s_araddr  = '0;
    bus.s_arlen   = '0;
    bus.s_rready  = 2'b11;
    bus.m_arready = 1'b0;
    bus.m_rvalid  = 1'b0;
    bus.m_rdata   = '0;
    bus.m_rresp   = '0;
    bus.m_rlast   = 1'b0;
    bus.m_rid     = '0;
    repeat (2) tick();

    check("rst_m_arvalid", bus.m_arvalid, 1'b0);
    check("rst_m_rready",  bus.m_rready,  1'b0);
    check("rst_s_arready", bus.s_arready, 2'b00);
    check("rst_s_rvalid",  bus.s_rvalid,  2'b00);
    check("arsize", bus.m_arsize, 3'd2);
    check("arburst", bus.m_arburst, 2'b01);
    resetn = 1'b1;

    // Single request: IDLE grant cycle, then AR in cycle 2
    set_req(0, 32'h100, 8'd1);
    bus.s_arvalid = 2'b01;
    bus.m_arready = 1'b1;
    tick();
    check("single_arvalid", bus.m_arvalid, 1'b1);
    check("single_arid",    bus.m_arid,    2'd0);
    check("single_araddr",  bus.m_araddr,  32'h100);
    check("single_arlen",   bus.m_arlen,   8'd1);
    check("single_arready", bus.s_arready, 2'b01);
    tick();
    bus.s_arvalid = 2'b00;
    check("single_data_arvalid", bus.m_arvalid, 1'b0);
    beat(32'hA0, 1'b0, 2'b01);
    beat(32'hA1, 1'b1, 2'b01);
    check("single_idle_arvalid", bus.m_arvalid, 1'b0);
    check("single_idle_rready",  bus.m_rready,  1'b0);
    $display("burst id=0 addr=00000100 beats=2");

    // Isolation: stray master R beat while idle
    bus.m_rvalid = 1'b1;
    bus.m_rlast  = 1'b1;
    #1;
    check("iso_rready", bus.m_rready, 1'b0);
    check("iso_rvalid", bus.s_rvalid, 2'b00);
    tick();
    check("iso_rvalid2", bus.s_rvalid, 2'b00);
    check("iso_arvalid", bus.m_arvalid, 1'b0);
    bus.m_rvalid = 1'b0;
    bus.m_rlast  = 1'b0;

    // AR backpressure then R backpressure on requester 1
    bus.m_arready = 1'b0;
    set_req(1, 32'h200, 8'd2);
    bus.s_arvalid = 2'b10;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("bp_arvalid", bus.m_arvalid, 1'b1);
      check("bp_araddr",  bus.m_araddr,  32'h200);
      check("bp_arlen",   bus.m_arlen,   8'd2);
      check("bp_arid",    bus.m_arid,    2'd1);
      check("bp_arready", bus.s_arready, 2'b00);
      tick();
    end
    bus.m_arready = 1'b1;
    #1;
    check("bp_arready_rise", bus.s_arready, 2'b10);
    tick();
    bus.s_arvalid = 2'b00;
    beat(32'hB0, 1'b0, 2'b10);
    bus.s_rready = 2'b01;
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'hB1;
    bus.m_rlast  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rbp_rready", bus.m_rready, 1'b0);
      check("rbp_rvalid", bus.s_rvalid, 2'b10);
      check("rbp_rdata",  bus.s_rdata,  32'hB1);
      tick();
    end
    bus.s_rready = 2'b11;
    beat(32'hB1, 1'b0, 2'b10);
    beat(32'hB2, 1'b1, 2'b10);
    check("rbp_idle", bus.m_arvalid, 1'b0);
    tick();
    check("rbp_idle2", bus.m_arvalid, 1'b0);
    $display("burst id=1 addr=00000200 beats=3");

    // Contention: both requesters held valid over four single-beat bursts
`ifdef NERV_AXI_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    set_req(0, 32'h400, 8'd0);
    set_req(1, 32'h500, 8'd0);
    bus.s_arvalid = 2'b11;
    for (int i = 0; i < 4; i++)
      run_burst(exp_order[i], (exp_order[i] == 0) ? 32'h400 : 32'h500, 1, 1'b0);
    bus.s_arvalid = 2'b00;

    // Requester 0 alone, so requester 1 would be next without a reset
    set_req(0, 32'h600, 8'd0);
    bus.s_arvalid = 2'b01;
    run_burst(0, 32'h600, 1, 1'b1);

    // Async reset while requester 1's second beat is pending
    set_req(1, 32'h700, 8'd1);
    bus.s_arvalid = 2'b10;
    tick();
    check("rst_mid_arid", bus.m_arid, 2'd1);
    tick();
    bus.s_arvalid = 2'b00;
    beat(32'h700, 1'b0, 2'b10);
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'h701;
    bus.m_rlast  = 1'b1;
    #1;
    check("rst_mid_rvalid", bus.s_rvalid, 2'b10);
    #1;
    resetn = 1'b0;
    #1;
    check("rst_async_arvalid", bus.m_arvalid, 1'b0);
    check("rst_async_rready",  bus.m_rready,  1'b0);
    check("rst_async_arready", bus.s_arready, 2'b00);
    check("rst_async_rvalid",  bus.s_rvalid,  2'b00);
    bus.m_rvalid = 1'b0;
    bus.m_rlast  = 1'b0;
    tick();
    resetn = 1'b1;
    set_req(0, 32'h800, 8'd0);
    bus.s_arvalid = 2'b11;
    run_burst(0, 32'h800, 1, 1'b0);
    bus.s_arvalid = 2'b00;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
